// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit types, port indices and allocator state encoding.
package noc_pkg;

  localparam int unsigned NUM_PORTS     = 5;
  localparam int unsigned PORT_W        = 3;
  localparam int unsigned FLIT_TYPE_MSB = 47;
  localparam int unsigned FLIT_TYPE_LSB = 45;
  localparam int unsigned FLIT_TYPE_W   = FLIT_TYPE_MSB - FLIT_TYPE_LSB + 1;
  localparam int unsigned SA_HOLD_LIMIT = 64;
  localparam int unsigned SA_HOLD_CNT_W = 7;

  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD      = 3'b000;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY      = 3'b001;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL      = 3'b010;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD_TAIL = 3'b011;

  typedef enum logic [2:0] {
    PORT_NORTH = 3'd0,
    PORT_EAST  = 3'd1,
    PORT_SOUTH = 3'd2,
    PORT_WEST  = 3'd3,
    PORT_LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } sa_state_e;

  function automatic logic is_head(input logic [FLIT_TYPE_W-1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
  endfunction

  function automatic logic is_body_tail(input logic [FLIT_TYPE_W-1:0] t);
    return (t == FLIT_BODY) || (t == FLIT_TAIL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping at NUM_PORTS-1.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned PORT_W    = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]    idx,
  output logic                 found
);
  import noc_pkg::*;

  logic [PORT_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (32'(ptr) + k >= NUM_PORTS) cand = PORT_W'(32'(ptr) + k - NUM_PORTS);
      else                           cand = PORT_W'(32'(ptr) + k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin on heads, locked to owner until tail.
// Optional sticky protocol checker built when SA_ERR_CHECK_EN is defined.
module switch_allocator #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned PORT_W    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS*PORT_W-1:0]   req_outport,
  input  logic [NUM_PORTS*3-1:0]        req_flit_type,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS*PORT_W-1:0]   xbar_sel,
  output logic [NUM_PORTS-1:0]          xbar_valid,
  output logic [3:0]                    err
);
  import noc_pkg::*;

  logic [PORT_W-1:0]    op [NUM_PORTS];
  logic [2:0]           ft [NUM_PORTS];

  sa_state_e            state_q [NUM_PORTS];
  sa_state_e            state_d [NUM_PORTS];
  logic [PORT_W-1:0]    owner_q [NUM_PORTS];
  logic [PORT_W-1:0]    owner_d [NUM_PORTS];
  logic [PORT_W-1:0]    ptr_q   [NUM_PORTS];
  logic [PORT_W-1:0]    ptr_d   [NUM_PORTS];
  logic [PORT_W-1:0]    sel_q   [NUM_PORTS];
  logic [PORT_W-1:0]    sel_d   [NUM_PORTS];

  logic [NUM_PORTS-1:0] arb_gnt   [NUM_PORTS];
  logic [PORT_W-1:0]    arb_idx   [NUM_PORTS];
  logic                 arb_found [NUM_PORTS];
  logic                 owner_ok  [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign op[gi] = req_outport[gi*PORT_W +: PORT_W];
    assign ft[gi] = req_flit_type[gi*3 +: 3];
  end

  // Per-output head candidates feed one arbiter each; owner_ok qualifies the locked path.
  for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out
    localparam logic [PORT_W-1:0] OUT_IDX = PORT_W'(go);
    logic [NUM_PORTS-1:0] cand;

    always_comb begin
      cand = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        cand[i] = req[i] && (op[i] == OUT_IDX) && is_head(ft[i]);
    end

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_arb (
      .req   (cand),
      .ptr   (ptr_q[go]),
      .gnt   (arb_gnt[go]),
      .idx   (arb_idx[go]),
      .found (arb_found[go])
    );

    assign owner_ok[go] = req[owner_q[go]] && (op[owner_q[go]] == OUT_IDX);
  end

  // Next-state and combinational grant/select for every output.
  always_comb begin
    grant      = '0;
    xbar_valid = '0;
    xbar_sel   = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      sel_d[o]   = sel_q[o];
      unique case (state_q[o])
        SA_IDLE: begin
          if (arb_found[o] && out_ready[o]) begin
            grant         = grant | arb_gnt[o];
            xbar_valid[o] = 1'b1;
            sel_d[o]      = arb_idx[o];
            ptr_d[o]      = (32'(arb_idx[o]) == NUM_PORTS - 1) ? '0
                                                               : arb_idx[o] + PORT_W'(1);
            if (ft[arb_idx[o]] == FLIT_HEAD) begin
              state_d[o] = SA_LOCKED;
              owner_d[o] = arb_idx[o];
            end
          end
        end
        SA_LOCKED: begin
          if (owner_ok[o] && out_ready[o]) begin
            grant[owner_q[o]] = 1'b1;
            xbar_valid[o]     = 1'b1;
            sel_d[o]          = owner_q[o];
            if (ft[owner_q[o]] == FLIT_TAIL) state_d[o] = SA_IDLE;
          end
        end
        default: state_d[o] = SA_IDLE;
      endcase
      xbar_sel[o*PORT_W +: PORT_W] = sel_d[o];
    end
    if (rst) begin
      grant      = '0;
      xbar_valid = '0;
      xbar_sel   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= SA_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
        sel_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
        sel_q[o]   <= sel_d[o];
      end
    end
  end

`ifdef SA_ERR_CHECK_EN
  logic [3:0]               err_q, err_d;
  logic [SA_HOLD_CNT_W-1:0] hold_q [NUM_PORTS];
  logic [SA_HOLD_CNT_W-1:0] hold_d [NUM_PORTS];

  // Sticky protocol checks; hold counter tracks owner silence while locked.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i]) begin
        if (32'(op[i]) >= NUM_PORTS) err_d[2] = 1'b1;
        else if ((state_q[op[i]] == SA_IDLE) && is_body_tail(ft[i])) err_d[0] = 1'b1;
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      hold_d[o] = '0;
      if (state_q[o] == SA_LOCKED) begin
        if (req[owner_q[o]] && is_head(ft[owner_q[o]])) err_d[1] = 1'b1;
        if (!req[owner_q[o]]) begin
          if (32'(hold_q[o]) == SA_HOLD_LIMIT) begin
            err_d[3]  = 1'b1;
            hold_d[o] = hold_q[o];
          end else begin
            hold_d[o] = hold_q[o] + SA_HOLD_CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) hold_q[o] <= '0;
    end else begin
      err_q <= err_d;
      for (int o = 0; o < NUM_PORTS; o++) hold_q[o] <= hold_d[o];
    end
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Crossbar (switch) allocator for one router. Collects `cba_request` from every input-port Buffer, arbitrates each output port round-robin among competing head flits, and holds the output locked to the winning input until that packet's tail flit has passed (wormhole). Drives `cba_grant` back to each Buffer and the per-output select lines of the crossbar switch.

## Interface
Parameters:
- `NUM_PORTS`, 5: router ports (N, E, S, W, local); inputs and outputs are both indexed 0..NUM_PORTS-1.
- `PORT_W`, 3: width of a port index; must be ≥ clog2(NUM_PORTS).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_PORTS  per-input request (Buffer `cba_request`).
- `req_outport`  in  NUM_PORTS*PORT_W  per-input requested output index, from RC; slice i = [i*PORT_W +: PORT_W].
- `req_flit_type`  in  NUM_PORTS*3  per-input flit type, i.e. bits [47:45] of `cbs_flit_out`.
- `out_ready`  in  NUM_PORTS  per-output downstream VC has space.
- `grant`  out  NUM_PORTS  per-input grant (Buffer `cba_grant`); the flit is consumed at the next rising edge.
- `xbar_sel`  out  NUM_PORTS*PORT_W  per-output selected input index.
- `xbar_valid`  out  NUM_PORTS  per-output flit transfer this cycle.
- `err`  out  4  sticky protocol-error flags (see Configuration).

## Operation
- Flit types: HEAD=3'b000, BODY=3'b001, TAIL=3'b010, HEAD_TAIL=3'b011 (single-flit packet).
- Each output o keeps: FSM state {IDLE, LOCKED}, owner[PORT_W], rr_ptr[PORT_W].
- IDLE: candidates are inputs i with req[i], req_outport[i]==o, and type HEAD or HEAD_TAIL. If at least one candidate exists and out_ready[o]=1, the winner is the first candidate found searching upward from rr_ptr, wrapping at NUM_PORTS-1→0.
  - On a win: grant[winner]=1, xbar_sel[o]=winner, xbar_valid[o]=1; rr_ptr ← (winner+1) mod NUM_PORTS.
  - HEAD win → LOCKED with owner=winner. HEAD_TAIL win → stays IDLE.
- LOCKED: only the owner is eligible. If req[owner] is set with outport o and out_ready[o]=1, the owner is granted. A TAIL grant → IDLE. BODY/TAIL from the owner otherwise hold the lock. All other inputs' requests to o are ignored.
- out_ready[o]=0: no grant for o; state and pointer are held; the requester retries.
- Each input requests one output, so grant is at most one-hot per input. xbar_sel holds its last value when xbar_valid=0.
- Request with req_outport ≥ NUM_PORTS: never granted.

## Timing
- grant, xbar_sel and xbar_valid are combinational from the inputs and registered state. Zero-cycle allocation: a head presented in cycle t with a free output and ready downstream is granted in cycle t.
- State, owner and rr_ptr update at the rising edge ending a granting cycle. Lock release takes effect at the edge ending the TAIL grant, so a new head can win in the following cycle.
- Throughput: one flit per output per cycle.
- Fairness bound: a waiting head wins within NUM_PORTS-1 packet completions on its output.
- Reset: all outputs IDLE, owner=0, rr_ptr=0, err=0. Reset mid-packet drops all locks; grant, xbar_valid and xbar_sel are 0 during the reset cycle.

## Configuration
- `SA_ERR_CHECK_EN` defined: err bits set sticky, cleared only by rst:
  - [0] BODY/TAIL request to an IDLE output.
  - [1] HEAD/HEAD_TAIL from the owner of a LOCKED output.
  - [2] req_outport ≥ NUM_PORTS.
  - [3] owner deasserts req for more than 64 consecutive cycles while LOCKED.
- Not defined: err is tied to 0 and no checker logic is built. Allocation behaviour is identical either way.

## Structure
- Shared package `noc_pkg`: flit-type constants, FLIT_TYPE_MSB/LSB (47/45), NUM_PORTS, PORT_W, the port-index enum.
- Sub-module `rr_arbiter` (NUM_PORTS-wide request vector plus pointer, returns one-hot grant and index), instantiated once per output via generate. Lock FSM, pointer update and error checks live in switch_allocator.

## Test plan
- Single HEAD_TAIL: input 1 → output 3, out_ready=all 1. Expect grant=5'b00010 in the same cycle, xbar_sel[3]=1, xbar_valid[3]=1, output 3 IDLE afterwards, rr_ptr[3]=2.
- Contention: inputs 0, 2, 4 present HEAD_TAIL to output 1 every cycle from reset. Expect grants in order 0, 2, 4, 0…, one per cycle.
- Wormhole lock: input 2 sends HEAD, BODY, BODY, TAIL to output 0 while input 3 holds HEAD to output 0. Input 3 gets no grant for 4 cycles, then is granted in cycle 5.
- Backpressure: out_ready[0]=0 for 3 cycles mid-packet. No grant during that time, lock held, transfer resumes when out_ready returns to 1.
- Reset mid-packet: assert rst after HEAD is granted. Next cycle a different input's HEAD to the same output is granted. With `SA_ERR_CHECK_EN` defined, the stale BODY from the old owner sets err[0].
